// File: rtl/univ_reg_bh.sv
// univ_reg_bh: WIDTH-bit universal register with load, shift, count, clear
// and invert modes, a registered carry/shift-out flag, status outputs and a
// tri-state driver onto the shared W-bus.
module univ_reg_bh #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_LSB,
    input  logic             SI_MSB,
    input  logic             OE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_BAR,
    output logic             CO,
    output logic             ZERO,
    output logic [WIDTH-1:0] BUS
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_INC  = 3'b100,
        MODE_DEC  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_INV  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_co;
    mode_e            w_mode;

    assign w_mode = mode_e'(MODE);

    // Next-state decode: one operation per enabled edge; disabled means hold.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_next_q  = r_q;
        w_next_co = r_co;
        if (EN) begin
            unique case (w_mode)
                MODE_HOLD: begin
                    w_next_q  = r_q;
                    w_next_co = r_co;
                end
                MODE_LOAD: begin
                    w_next_q  = D;
                    w_next_co = 1'b0;
                end
                MODE_SHL: begin
                    w_next_q  = {r_q[WIDTH-2:0], SI_LSB};
                    w_next_co = r_q[WIDTH-1];
                end
                MODE_SHR: begin
                    w_next_q  = {SI_MSB, r_q[WIDTH-1:1]};
                    w_next_co = r_q[0];
                end
                MODE_INC: begin
                    w_next_q  = r_q + 1'b1;
                    w_next_co = &r_q;
                end
                MODE_DEC: begin
                    w_next_q  = r_q - 1'b1;
                    w_next_co = ~|r_q;
                end
                MODE_CLR: begin
                    // Clear goes to zero, deliberately not to RESET_VAL.
                    w_next_q  = '0;
                    w_next_co = 1'b0;
                end
                MODE_INV: begin
                    w_next_q  = ~r_q;
                    w_next_co = 1'b0;
                end
                default: begin
                    w_next_q  = r_q;
                    w_next_co = r_co;
                end
            endcase
        end
    end

    // State register: asynchronous reset to RESET_VAL with carry cleared.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (RST) begin
            r_q  <= RESET_VAL;
            r_co <= 1'b0;
        end else begin
            r_q  <= w_next_q;
            r_co <= w_next_co;
        end
    end

    // Combinational views of the stored word; OE acts with no latency.
    assign Q     = r_q;
    assign Q_BAR = ~r_q;
    assign CO    = r_co;
    assign ZERO  = (r_q == '0);
    assign BUS   = OE ? r_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_univ_reg_bh.sv
// tb_univ_reg_bh: table-driven vectors with a scoreboard queue, plus
// hand-written sequences for asynchronous reset and reset mid-count.
module tb_univ_reg_bh;

    localparam int unsigned      WIDTH     = 8;
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h3C;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_INC  = 3'b100;
    localparam logic [2:0] M_DEC  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_INV  = 3'b111;

    typedef struct {
        logic             en;
        logic [2:0]       mode;
        logic [WIDTH-1:0] d;
        logic             si_lsb;
        logic             si_msb;
        logic             oe;
        logic [WIDTH-1:0] exp_q;
        logic             exp_co;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             co;
        logic             oe;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SI_LSB;
    logic             SI_MSB;
    logic             OE;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_BAR;
    logic             CO;
    logic             ZERO;
    logic [WIDTH-1:0] BUS;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    univ_reg_bh #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .MODE   (MODE),
        .D      (D),
        .SI_LSB (SI_LSB),
        .SI_MSB (SI_MSB),
        .OE     (OE),
        .Q      (Q),
        .Q_BAR  (Q_BAR),
        .CO     (CO),
        .ZERO   (ZERO),
        .BUS    (BUS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against one expected state.
    task automatic check_state(input string tag, input logic [WIDTH-1:0] q,
                               input logic co, input logic oe);
        logic [WIDTH-1:0] exp_bus;
        exp_bus = oe ? q : {WIDTH{1'bz}};
        check({tag, " Q"},     Q,            q);
        check({tag, " Q_BAR"}, Q_BAR,        ~q);
        check({tag, " CO"},    {7'b0, CO},   {7'b0, co});
        check({tag, " ZERO"},  {7'b0, ZERO}, {7'b0, (q == '0)});
        check({tag, " BUS"},   BUS,          exp_bus);
    endtask

    // Drive one vector mid-cycle, queue its expectation, compare after the edge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        EN     = v.en;
        MODE   = v.mode;
        D      = v.d;
        SI_LSB = v.si_lsb;
        SI_MSB = v.si_msb;
        OE     = v.oe;
        sb.push_back('{q: v.exp_q, co: v.exp_co, oe: v.oe});
        @(posedge CLK);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_state(tag, e.q, e.co, e.oe);
        end
    endtask

    vec_t vecs[20];

    initial begin
        // en, mode, d, si_lsb, si_msb, oe, exp_q, exp_co
        vecs[0]  = '{1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{1'b0, M_INV,  8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[2]  = '{1'b0, M_INV,  8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[3]  = '{1'b0, M_INV,  8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[4]  = '{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0};
        vecs[5]  = '{1'b1, M_SHL,  8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1};
        vecs[6]  = '{1'b1, M_SHR,  8'h00, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[7]  = '{1'b1, M_SHR,  8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1};
        vecs[8]  = '{1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h40, 1'b1};
        vecs[9]  = '{1'b0, M_LOAD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1};
        vecs[10] = '{1'b1, M_LOAD, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0};
        vecs[11] = '{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[12] = '{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[13] = '{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[14] = '{1'b1, M_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b1, M_DEC,  8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1};
        vecs[16] = '{1'b1, M_DEC,  8'h00, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0};
        vecs[17] = '{1'b1, M_INV,  8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[18] = '{1'b1, M_CLR,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[19] = '{1'b1, M_SHL,  8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0};

        RST    = 1'b0;
        EN     = 1'b0;
        MODE   = M_HOLD;
        D      = '0;
        SI_LSB = 1'b0;
        SI_MSB = 1'b0;
        OE     = 1'b0;

        // Asynchronous reset asserted between clock edges takes effect at once.
        #3;
        RST = 1'b1;
        #1;
        check_state("reset", RESET_VAL, 1'b0, 1'b0);
        OE = 1'b1;
        #1;
        check_state("reset oe", RESET_VAL, 1'b0, 1'b1);
        OE = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Count up from zero, then hit reset asynchronously mid-count.
        step("cnt load", '{1'b1, M_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("cnt%0d", i),
                 '{1'b1, M_INC, 8'h00, 1'b0, 1'b0, 1'b0, WIDTH'(i), 1'b0});
        end
        #3;
        RST = 1'b1;
        #1;
        check_state("midcount rst", RESET_VAL, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check_state("rst held", RESET_VAL, 1'b0, 1'b0);
        RST = 1'b0;
        step("rst release inc", '{1'b1, M_INC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3D, 1'b0});

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
